// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised serial pattern detector.
// State encoding is exposed on the top-level port, so its values are fixed here.
package seq_det_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_ARMED = 2'd2
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-high reset.
// Holds at all-ones once reached instead of wrapping.
module sat_counter
    import seq_det_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    // Clear wins over increment; saturation is checked against all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Mealy serial pattern detector with loadable pattern, overlap control and exposed state.
// Optional saturating match counter is enabled by defining SEQ_DET_MATCH_COUNT_EN.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W     = 4,
    parameter logic [PAT_W-1:0] PAT_RESET = 4'b1011,
    parameter int               CNT_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               data,
    input  logic               data_valid,
    input  logic [PAT_W-1:0]   pat_in,
    input  logic               pat_load,
    input  logic               overlap_en,
    output logic               out,
    output logic [STATE_W-1:0] state,
    output logic [CNT_W-1:0]   match_cnt
);

    localparam int                FILL_W   = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    logic [PAT_W-1:0]  pat_q;
    logic [PAT_W-2:0]  hist;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fillInc;
    state_t            stateQ;
    state_t            stateInc;
    logic [PAT_W-1:0]  window;
    logic              accept;
    logic              hit;

    // The candidate window is the stored history plus the bit on the wire right now.
    assign window = {hist, data};
    assign accept = data_valid & ~pat_load;
    assign hit    = accept & (stateQ == S_ARMED) & (window == pat_q);
    assign out    = hit;
    assign state  = stateQ;

    always_comb begin
        fillInc  = fill;
        stateInc = S_FILL;
        if (fill != FILL_MAX) begin
            fillInc = fill + 1'b1;
        end
        if (fillInc == FILL_MAX) begin
            stateInc = S_ARMED;
        end
    end

    // A pattern load restarts detection from scratch and drops the concurrent bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q  <= PAT_RESET;
            hist   <= '0;
            fill   <= '0;
            stateQ <= S_IDLE;
        end else if (pat_load) begin
            pat_q  <= pat_in;
            hist   <= '0;
            fill   <= '0;
            stateQ <= S_IDLE;
        end else if (data_valid) begin
            hist <= window[PAT_W-2:0];
            if (hit && !overlap_en) begin
                fill   <= '0;
                stateQ <= S_IDLE;
            end else begin
                fill   <= fillInc;
                stateQ <= stateInc;
            end
        end
    end

`ifdef SEQ_DET_MATCH_COUNT_EN
    sat_counter #(
        .W(CNT_W)
    ) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .inc (hit),
        .clr (pat_load),
        .cnt (match_cnt)
    );
`else
    assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed self-checking bench for seq_detector_param (PAT_W=4, CNT_W=2).
// Expected counter values follow SEQ_DET_MATCH_COUNT_EN.
module tb_seq_detector_param;
    import seq_det_pkg::*;

    logic         clk;
    logic         rst;
    logic         data;
    logic         data_valid;
    logic [3:0]   pat_in;
    logic         pat_load;
    logic         overlap_en;
    logic         out;
    logic [1:0]   state;
    logic [1:0]   match_cnt;

    int checkCount = 0;
    int errorCount = 0;

    seq_detector_param #(
        .PAT_W     (4),
        .PAT_RESET (4'b1011),
        .CNT_W     (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .data_valid (data_valid),
        .pat_in     (pat_in),
        .pat_load   (pat_load),
        .overlap_en (overlap_en),
        .out        (out),
        .state      (state),
        .match_cnt  (match_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] expCnt(input int n);
`ifdef SEQ_DET_MATCH_COUNT_EN
        return (n > 3) ? 32'd3 : 32'(n);
`else
        return (n > 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Present one valid bit, check the combinational flag, then clock it in.
    task automatic applyStimulus(input logic d, input logic expOut, input string tag);
        @(negedge clk);
        data       = d;
        data_valid = 1'b1;
        pat_load   = 1'b0;
        #1;
        checkOutput(tag, {31'd0, out}, {31'd0, expOut});
        @(posedge clk);
        #1;
        data_valid = 1'b0;
    endtask

    task automatic gapCycle(input string tag);
        @(negedge clk);
        data       = 1'b1;
        data_valid = 1'b0;
        #1;
        checkOutput(tag, {31'd0, out}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic loadPattern(input logic [3:0] p, input logic d, input logic v, input string tag);
        @(negedge clk);
        pat_in     = p;
        pat_load   = 1'b1;
        data       = d;
        data_valid = v;
        #1;
        checkOutput({tag, "_out"}, {31'd0, out}, 32'd0);
        @(posedge clk);
        #1;
        pat_load   = 1'b0;
        data_valid = 1'b0;
        checkOutput({tag, "_state"}, {30'd0, state}, {30'd0, S_IDLE});
        checkOutput({tag, "_cnt"}, {30'd0, match_cnt}, 32'd0);
    endtask

    task automatic runStream(input logic [7:0] bits, input logic [7:0] expOut, input int len, input string tag);
        for (int i = len - 1; i >= 0; i--) begin
            applyStimulus(bits[i], expOut[i], $sformatf("%s_bit%0d", tag, len - i));
        end
    endtask

    initial begin
        rst        = 1'b1;
        data       = 1'b0;
        data_valid = 1'b0;
        pat_in     = 4'b0000;
        pat_load   = 1'b0;
        overlap_en = 1'b1;
        #3;
        checkOutput("reset_state", {30'd0, state}, {30'd0, S_IDLE});
        checkOutput("reset_out", {31'd0, out}, 32'd0);
        checkOutput("reset_cnt", {30'd0, match_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Overlapping matches on the default pattern 1011.
        applyStimulus(1'b1, 1'b0, "ov_b1");
        applyStimulus(1'b0, 1'b0, "ov_b2");
        checkOutput("ov_state_fill", {30'd0, state}, {30'd0, S_FILL});
        applyStimulus(1'b1, 1'b0, "ov_b3");
        checkOutput("ov_state_armed", {30'd0, state}, {30'd0, S_ARMED});
        runStream(8'b0000_1011, 8'b0000_1001, 4, "ov_tail");
        checkOutput("ov_cnt", {30'd0, match_cnt}, expCnt(2));

        // Non-overlapping: second occurrence shares bits, so it is missed.
        overlap_en = 1'b0;
        loadPattern(4'b1011, 1'b0, 1'b0, "nov_load");
        runStream(8'b0000_1011, 8'b0000_0001, 4, "nov_a");
        checkOutput("nov_state_idle", {30'd0, state}, {30'd0, S_IDLE});
        runStream(8'b0000_0011, 8'b0000_0000, 3, "nov_b");
        checkOutput("nov_state_armed", {30'd0, state}, {30'd0, S_ARMED});
        checkOutput("nov_cnt", {30'd0, match_cnt}, expCnt(1));

        // Gaps in data_valid are transparent.
        overlap_en = 1'b1;
        loadPattern(4'b1011, 1'b0, 1'b0, "gap_load");
        runStream(8'b0000_0010, 8'b0000_0000, 2, "gap_a");
        for (int g = 0; g < 3; g++) begin
            gapCycle($sformatf("gap_idle%0d", g));
        end
        checkOutput("gap_state_hold", {30'd0, state}, {30'd0, S_FILL});
        runStream(8'b0000_0011, 8'b0000_0001, 2, "gap_b");
        checkOutput("gap_cnt", {30'd0, match_cnt}, expCnt(1));

        // Re-arm with history 101 so a 1 would match, then load over it.
        runStream(8'b0000_0001, 8'b0000_0000, 2, "ld_pre");
        loadPattern(4'b0110, 1'b1, 1'b1, "ld_new");
        runStream(8'b0000_0110, 8'b0000_0001, 4, "ld_stream");
        checkOutput("ld_cnt", {30'd0, match_cnt}, expCnt(1));

        // Asynchronous reset between edges; pattern reverts to 1011.
        loadPattern(4'b1011, 1'b0, 1'b0, "ar_load");
        runStream(8'b0000_0101, 8'b0000_0000, 3, "ar_pre");
        @(negedge clk);
        data       = 1'b1;
        data_valid = 1'b1;
        #1;
        checkOutput("ar_preview_out", {31'd0, out}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("ar_out", {31'd0, out}, 32'd0);
        checkOutput("ar_state", {30'd0, state}, {30'd0, S_IDLE});
        checkOutput("ar_cnt", {30'd0, match_cnt}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("ar_state_held", {30'd0, state}, {30'd0, S_IDLE});
        @(negedge clk);
        rst        = 1'b0;
        data_valid = 1'b0;
        applyStimulus(1'b1, 1'b0, "ar_lone");
        checkOutput("ar_lone_state", {30'd0, state}, {30'd0, S_FILL});
        runStream(8'b0000_1011, 8'b0000_0001, 4, "ar_post");

        // All-ones pattern with overlap matches every bit once armed; counter saturates.
        loadPattern(4'b1111, 1'b0, 1'b0, "sat_load");
        runStream(8'b0001_1111, 8'b0000_0011, 5, "sat_a");
        checkOutput("sat_cnt_mid", {30'd0, match_cnt}, expCnt(2));
        runStream(8'b0000_0111, 8'b0000_0111, 3, "sat_b");
        checkOutput("sat_cnt_end", {30'd0, match_cnt}, expCnt(5));

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
